// File: rtl/gpmc_initiator.sv
// rtl/gpmc_initiator.sv - single-word GPMC bus initiator (multiplexed 16-bit AD)
module gpmc_initiator #(
   parameter int ADDR_W   = 11,
   parameter int ADV_CYC  = 2,
   parameter int ACC_CYC  = 3,
   parameter int TURN_CYC = 1
) (
   input  logic              GPMC_CLK,
   input  logic              GPMC_RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   input  logic [1:0]        req_be,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic [15:0]       GPMC_AD_OUT,
   input  logic [15:0]       GPMC_AD_IN,
   output logic              GPMC_AD_OE,
   output logic              GPMC_CS,
   output logic              GPMC_ADV,
   output logic              GPMC_OE,
   output logic              GPMC_WE,
   output logic              GPMC_BE0,
   output logic              GPMC_BE1,
   output logic              GPMC_WP,
   output logic              GPMC_DIR
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_TURN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [1:0]        be_q, be_d;

   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rsp_rdata_q, rsp_rdata_d;
   logic [15:0]       ad_out_q, ad_out_d;
   logic              ad_oe_q, ad_oe_d;
   logic              cs_q, cs_d;
   logic              adv_q, adv_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              be0_q, be0_d;
   logic              be1_q, be1_d;
   logic              dir_q, dir_d;

   // Next-state: phase sequencing with one shared down-counter, request latching
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d    = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               state_d = S_ADDR;
               cnt_d   = 4'(ADV_CYC - 1);
            end
         end
         S_ADDR: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACCESS;
               cnt_d   = 4'(ACC_CYC - 1);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_TURN;
               cnt_d   = 4'(TURN_CYC - 1);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   // Outputs: decoded from the upcoming state so every pin is a flop
   always_comb begin
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      ad_out_d    = 16'h0000;
      ad_oe_d     = 1'b0;
      cs_d        = 1'b1;
      adv_d       = 1'b1;
      oe_d        = 1'b1;
      we_d        = 1'b1;
      be0_d       = 1'b1;
      be1_d       = 1'b1;
      dir_d       = 1'b0;
      case (state_d)
         S_IDLE: req_ready_d = 1'b1;
         S_ADDR: begin
            cs_d                = 1'b0;
            adv_d               = 1'b0;
            ad_oe_d             = 1'b1;
            ad_out_d[ADDR_W-1:0] = addr_d;
         end
         S_ACCESS: begin
            cs_d = 1'b0;
            if (wr_d) begin
               ad_oe_d  = 1'b1;
               ad_out_d = wdata_d;
               we_d     = 1'b0;
               be0_d    = ~be_d[0];
               be1_d    = ~be_d[1];
            end else begin
               oe_d  = 1'b0;
               be0_d = 1'b0;
               be1_d = 1'b0;
               dir_d = 1'b1;
            end
         end
         default: ;
      endcase
      // Leaving ACCESS is the edge that ends the last data cycle: sample read data here
      if (state_q == S_ACCESS && state_d == S_TURN) begin
         rsp_valid_d = 1'b1;
         if (!wr_q) rsp_rdata_d = GPMC_AD_IN;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge GPMC_CLK) begin
      if (GPMC_RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         be_q        <= 2'b00;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         ad_out_q    <= 16'h0000;
         ad_oe_q     <= 1'b0;
         cs_q        <= 1'b1;
         adv_q       <= 1'b1;
         oe_q        <= 1'b1;
         we_q        <= 1'b1;
         be0_q       <= 1'b1;
         be1_q       <= 1'b1;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         ad_out_q    <= ad_out_d;
         ad_oe_q     <= ad_oe_d;
         cs_q        <= cs_d;
         adv_q       <= adv_d;
         oe_q        <= oe_d;
         we_q        <= we_d;
         be0_q       <= be0_d;
         be1_q       <= be1_d;
         dir_q       <= dir_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign GPMC_AD_OUT = ad_out_q;
   assign GPMC_AD_OE  = ad_oe_q;
   assign GPMC_CS     = cs_q;
   assign GPMC_ADV    = adv_q;
   assign GPMC_OE     = oe_q;
   assign GPMC_WE     = we_q;
   assign GPMC_BE0    = be0_q;
   assign GPMC_BE1    = be1_q;
   assign GPMC_WP     = 1'b1;
   assign GPMC_DIR    = dir_q;

endmodule
